cic_comp_fir: RTL

//  CIC droop-compensation FIR with optional decimation. It sits directly downstream of the

---
 rtl/cic_comp_fir_if.sv | 17 +
 rtl/cic_comp_fir.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cic_comp_fir_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cic_comp_fir_if : sample-stream bundle between CIC chain and compensator
// Rev 1.0
// ---------------------------------------------------------------------------
interface cic_comp_fir_if;
  logic               cke;
  logic signed [15:0] din;
  logic signed [15:0] dout;
  logic               cke_out;
  logic               busy;
  logic               overrun;

  modport master (output cke, din, input dout, cke_out, busy, overrun);
  modport slave  (input cke, din, output dout, cke_out, busy, overrun);
endinterface
`default_nettype wire

// File: rtl/cic_comp_fir.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cic_comp_fir : 8-tap CIC droop-compensation FIR, serial MAC, DECIM 1 or 2
// Rev 1.0
// ---------------------------------------------------------------------------
module cic_comp_fir #(
  parameter int DECIM = 1,
  parameter int TAPS  = 8
) (
  input  logic           clk,
  input  logic           rst,
  cic_comp_fir_if.slave  bus
);

  localparam int               c_kw    = $clog2(TAPS);
  localparam logic [c_kw-1:0]  c_klast = c_kw'(TAPS - 1);
  localparam logic [1:0]       c_idle  = 2'd0;
  localparam logic [1:0]       c_mac   = 2'd1;
  localparam logic [1:0]       c_out   = 2'd2;
  localparam logic signed [15:0] c_coef [TAPS] = '{
    -16'sd256, 16'sd512, -16'sd1024, 16'sd8960,
     16'sd8960, -16'sd1024, 16'sd512, -16'sd256
  };

  logic [1:0]         r_state;
  logic signed [15:0] r_dly [TAPS];
  logic [c_kw-1:0]    r_k;
  logic signed [35:0] r_acc;
  logic signed [15:0] r_dout;
  logic               r_cke_out;
  logic               r_overrun;

  logic               w_accept;
  logic               w_start;
  logic signed [15:0] w_tap;
  logic signed [15:0] w_coef;
  logic signed [31:0] w_prod;
  logic signed [35:0] w_sum;
  logic signed [35:0] w_rnd;
  logic signed [15:0] w_sat;

  assign w_accept = bus.cke && (r_state == c_idle);
  assign w_tap    = r_dly[r_k];
  assign w_coef   = c_coef[r_k];
  assign w_prod   = w_tap * w_coef;
  assign w_sum    = r_acc + 36'(w_prod);
  assign w_rnd    = (w_sum + 36'sd8192) >>> 14;

  always_comb begin
    w_sat = w_rnd[15:0];
    if (w_rnd > 36'sd32767)
      w_sat = 16'sh7fff;
    else if (w_rnd < -36'sd32768)
      w_sat = 16'sh8000;
  end

  generate
    if (DECIM == 2) begin : g_decim2
      // Phase 0 = first sample of a pair (no MAC), phase 1 = second (MAC).
      logic r_phase;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          r_phase <= 1'b0;
        else if (w_accept)
          r_phase <= ~r_phase;
      end
      assign w_start = r_phase;
    end else begin : g_decim1
      assign w_start = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_idle;
      r_k       <= '0;
      r_acc     <= '0;
      r_dout    <= '0;
      r_cke_out <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < TAPS; i++)
        r_dly[i] <= '0;
    end else begin
      r_cke_out <= 1'b0;
      if (bus.cke && (r_state != c_idle))
        r_overrun <= 1'b1;
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_dly[0] <= bus.din;
            for (int i = 1; i < TAPS; i++)
              r_dly[i] <= r_dly[i-1];
            if (w_start) begin
              r_state <= c_mac;
              r_acc   <= '0;
              r_k     <= '0;
            end
          end
        end
        c_mac: begin
          r_acc <= w_sum;
          r_k   <= r_k + 1'b1;
          // Final product is folded in combinationally so dout lands in the OUT cycle.
          if (r_k == c_klast) begin
            r_dout    <= w_sat;
            r_cke_out <= 1'b1;
            r_state   <= c_out;
          end
        end
        c_out:   r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  assign bus.dout    = r_dout;
  assign bus.cke_out = r_cke_out;
  assign bus.busy    = (r_state != c_idle);
  assign bus.overrun = r_overrun;

endmodule
`default_nettype wire
